// File: rtl/tns_link_scheduler_if.sv
// rtl/tns_link_scheduler_if.sv - requester-side handshake bundle for tns_link_scheduler
// Purpose: groups the two requesters' valid/data/ready signals.
// Signals:
//   req_valid [1:0]         per-requester word valid
//   req_data  [2*DATA_W-1:0] requester i word in bits [i*DATA_W +: DATA_W]
//   req_ready [1:0]         one-hot accept from the scheduler
// Modports: master (requester side), slave (scheduler side).
interface tns_link_scheduler_if #(
    parameter int DATA_W = 16
) ();
    logic [1:0]          req_valid;
    logic [2*DATA_W-1:0] req_data;
    logic [1:0]          req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/tns_link_scheduler.sv
// rtl/tns_link_scheduler.sv - round-robin scheduler sharing one TNS_encoder_21 link between 2 requesters
// Purpose: arbitrates two requesters onto the encoder datain register, holds datain while idle,
//   drives zero words during post-reset warm-up, and pipelines code_valid/code_src to line up
//   with the encoder's 1-cycle codeout latency.
// Ports:
//   clock, rst_n         clock (rising edge), async active-low reset
//   req_if (slave)       req_valid/req_data in, req_ready out (combinational one-hot grant)
//   enc_datain, enc_load registered word to the encoder and its new-word strobe
//   code_valid, code_src enc_load and its requester id delayed one cycle
//   busy                 warm-up in progress or any request pending
// Optional: define TNS_SCHED_STATS_EN to add stat_words0/stat_words1/stat_switches counters.
module tns_link_scheduler #(
    parameter int DATA_W     = 16,
    parameter int MAX_BURST  = 4,
    parameter int WARMUP_CYC = 2
) (
    input  logic                   clock,
    input  logic                   rst_n,
    tns_link_scheduler_if.slave    req_if,
    output logic [DATA_W-1:0]      enc_datain,
    output logic                   enc_load,
    output logic                   code_valid,
    output logic                   code_src,
    output logic                   busy
`ifdef TNS_SCHED_STATS_EN
    ,
    output logic [31:0]            stat_words0,
    output logic [31:0]            stat_words1,
    output logic [15:0]            stat_switches
`endif
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int WW = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;

    typedef enum logic [1:0] {S_WARMUP, S_IDLE, S_SERVE} state_t;

    state_t            r_state, w_state_nxt;
    logic [WW-1:0]     r_warm_cnt;
    logic [BW-1:0]     r_burst_cnt;
    logic              r_rr_ptr;
    logic              r_owner;
    logic [DATA_W-1:0] r_enc_datain;
    logic              r_enc_load;
    logic              r_enc_src;
    logic              r_code_valid;
    logic              r_code_src;

    logic [1:0]        w_valid;
    logic              w_gnt_any;
    logic              w_gnt_id;
    logic              w_switch;
    logic [DATA_W-1:0] w_sel_data;

    assign w_valid = req_if.req_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_any   = 1'b0;
        w_gnt_id    = r_owner;
        case (r_state)
            S_WARMUP: begin
                if (r_warm_cnt == WW'(WARMUP_CYC - 1))
                    w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (|w_valid) begin
                    w_gnt_any   = 1'b1;
                    w_gnt_id    = (&w_valid) ? r_rr_ptr : w_valid[1];
                    w_state_nxt = S_SERVE;
                end
            end
            S_SERVE: begin
                if (w_valid[r_owner] && (r_burst_cnt < BW'(MAX_BURST))) begin
                    w_gnt_any = 1'b1;
                    w_gnt_id  = r_owner;
                end else if (w_valid[~r_owner]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_id  = ~r_owner;
                end else if (w_valid[r_owner]) begin
                    // Burst limit only matters while the other side waits.
                    w_gnt_any = 1'b1;
                    w_gnt_id  = r_owner;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_WARMUP;
        endcase
    end

    assign w_switch   = w_gnt_any && (w_gnt_id != r_owner);
    assign w_sel_data = w_gnt_id ? req_if.req_data[DATA_W +: DATA_W] : req_if.req_data[0 +: DATA_W];

    assign req_if.req_ready = w_gnt_any ? (2'b01 << w_gnt_id) : 2'b00;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_WARMUP;
            r_warm_cnt   <= '0;
            r_burst_cnt  <= '0;
            r_rr_ptr     <= 1'b0;
            r_owner      <= 1'b0;
            r_enc_datain <= '0;
            r_enc_load   <= 1'b0;
            r_enc_src    <= 1'b0;
            r_code_valid <= 1'b0;
            r_code_src   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_enc_load   <= w_gnt_any;
            r_code_valid <= r_enc_load;
            r_code_src   <= r_enc_src;
            if (r_state == S_WARMUP) begin
                r_warm_cnt   <= r_warm_cnt + 1'b1;
                r_enc_datain <= '0;
            end
            if (w_gnt_any) begin
                r_enc_datain <= w_sel_data;
                r_enc_src    <= w_gnt_id;
                r_owner      <= w_gnt_id;
                if (w_switch) begin
                    r_rr_ptr    <= ~w_gnt_id;
                    r_burst_cnt <= BW'(1);
                end else if (r_state == S_IDLE) begin
                    // A grant out of IDLE starts a fresh burst even for the same owner.
                    r_burst_cnt <= BW'(1);
                end else if (r_burst_cnt < BW'(MAX_BURST)) begin
                    r_burst_cnt <= r_burst_cnt + 1'b1;
                end
            end
        end
    end

    assign enc_datain = r_enc_datain;
    assign enc_load   = r_enc_load;
    assign code_valid = r_code_valid;
    assign code_src   = r_code_src;
    assign busy       = (r_state == S_WARMUP) || (|w_valid);

`ifdef TNS_SCHED_STATS_EN
    logic [31:0] r_stat_words0, r_stat_words1;
    logic [15:0] r_stat_switches;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_words0   <= '0;
            r_stat_words1   <= '0;
            r_stat_switches <= '0;
        end else begin
            if (w_gnt_any && !w_gnt_id) r_stat_words0 <= r_stat_words0 + 1'b1;
            if (w_gnt_any &&  w_gnt_id) r_stat_words1 <= r_stat_words1 + 1'b1;
            if (w_switch)               r_stat_switches <= r_stat_switches + 1'b1;
        end
    end

    assign stat_words0   = r_stat_words0;
    assign stat_words1   = r_stat_words1;
    assign stat_switches = r_stat_switches;
`endif
endmodule
